// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Shared types and constants for the iterative shift sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int SHAMT_W_DEF = 5;
    localparam int NUM_STAGES  = 5;
    localparam int STAGE_W     = $clog2(NUM_STAGES);

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_RSV = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_e;

endpackage

`default_nettype wire

// File: rtl/shift_stage.sv
// ============================================================================
// Module      : shift_stage
// Description : One conditional binary shift stage (shift by 2^stage if enabled).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_stage
    import shift_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic [XLEN-1:0]    i_data,
    input  shift_op_e          i_op,
    input  logic               i_sign,
    input  logic [STAGE_W-1:0] i_stage,
    input  logic               i_en,
    output logic [XLEN-1:0]    o_data
);

    logic [SHAMT_W-1:0] w_amt;
    logic [XLEN-1:0]    w_fill;

    always_comb begin
        w_amt  = SHAMT_W'(1) << i_stage;
        // Ones in exactly the MSB positions vacated by a right shift of w_amt.
        w_fill = ~({XLEN{1'b1}} >> w_amt);
        o_data = i_data;
        if (i_en) begin
            case (i_op)
                SH_SLL:  o_data = i_data << w_amt;
                SH_SRL:  o_data = i_data >> w_amt;
                SH_SRA:  o_data = (i_data >> w_amt) | (i_sign ? w_fill : '0);
                default: o_data = i_data;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
// ============================================================================
// Module      : shift_seq_ctrl
// Description : Iterative SLL/SRL/SRA sequencer, one binary stage per cycle.
//               Optional macro SHIFT_EARLY_DONE_EN skips trailing zero stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter  int XLEN    = XLEN_DEF,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] data_in,
    input  logic [31:0]     shift_amount,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] data_out,
    output logic            busy
);

    shift_state_e       r_state;
    shift_state_e       w_state_nx;
    logic [STAGE_W-1:0] r_stage;
    logic [XLEN-1:0]    r_work;
    logic [SHAMT_W-1:0] r_shamt;
    shift_op_e          r_op;
    logic               r_sign;
    logic [XLEN-1:0]    r_data_out;
    logic               r_out_valid;

    logic [XLEN-1:0]    w_stage_out;
    logic [SHAMT_W-1:0] w_shamt_in;
    logic               w_accept;
    logic               w_last;
    logic               w_skip;
    logic               w_unused_amt;

    assign w_shamt_in   = shift_amount[SHAMT_W-1:0];
    assign w_unused_amt = ^shift_amount[31:SHAMT_W];
    assign w_accept     = in_valid && in_ready;

`ifdef SHIFT_EARLY_DONE_EN
    logic [SHAMT_W-1:0] w_rest;
    // Done once no higher shamt bit remains beyond the current stage.
    assign w_rest = r_shamt >> r_stage;
    assign w_last = (w_rest[SHAMT_W-1:1] == '0);
    assign w_skip = (w_shamt_in == '0);
`else
    assign w_last = (r_stage == STAGE_W'(NUM_STAGES - 1));
    assign w_skip = 1'b0;
`endif

    shift_stage #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_stage (
        .i_data  (r_work),
        .i_op    (r_op),
        .i_sign  (r_sign),
        .i_stage (r_stage),
        .i_en    (r_shamt[r_stage]),
        .o_data  (w_stage_out)
    );

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nx = w_skip ? DONE : SHIFT;
            SHIFT:   if (w_last) w_state_nx = DONE;
            DONE:    if (out_ready) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_stage     <= '0;
            r_work      <= '0;
            r_shamt     <= '0;
            r_op        <= SH_SLL;
            r_sign      <= 1'b0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_work  <= data_in;
                        r_shamt <= w_shamt_in;
                        r_op    <= shift_op_e'(op);
                        r_sign  <= data_in[XLEN-1];
                        r_stage <= '0;
                        if (w_skip) begin
                            r_data_out  <= data_in;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    r_work  <= w_stage_out;
                    r_stage <= r_stage + STAGE_W'(1);
                    if (w_last) begin
                        r_data_out  <= w_stage_out;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
// ============================================================================
// Module      : tb_shift_seq_ctrl
// Description : Self-checking bench for shift_seq_ctrl against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [31:0] shift_amount;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op           (op),
        .data_in      (data_in),
        .shift_amount (shift_amount),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .busy         (busy)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                              input logic [31:0] s);
        int                 n;
        logic signed [31:0] sd;
        n  = int'(s % 32);
        sd = d;
        case (o)
            2'd0:    return d << n;
            2'd1:    return d >> n;
            2'd2:    return sd >>> n;
            default: return d;
        endcase
    endfunction

    // Edges after the accepting edge until out_valid is seen high.
    function automatic int ref_lat(input logic [31:0] s);
        int n;
        n = int'(s % 32);
`ifdef SHIFT_EARLY_DONE_EN
        if (n == 0) return 0;  // DONE is entered on the accepting edge itself
        for (int b = 4; b >= 0; b--)
            if (((n >> b) & 1) == 1) return b + 1;
        return 0;
`else
        return (n >= 0) ? 5 : 5;
`endif
    endfunction

    task automatic wait_ready;
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick;
            w++;
        end
        chk_eq("in_ready_idle", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [31:0] s,
                          input int hold);
        int          lat;
        logic [31:0] exp;
        logic [31:0] held;
        exp = ref_shift(o, d, s);
        wait_ready;
        in_valid     = 1'b1;
        op           = o;
        data_in      = d;
        shift_amount = s;
        tick;
        // Scrambled inputs with in_valid still high must not disturb the result.
        op           = 2'($urandom);
        data_in      = $urandom;
        shift_amount = $urandom;
        chk_eq("busy_after_accept", 32'(busy), 32'd1);
        chk_eq("in_ready_busy", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick;
            lat++;
        end
        in_valid = 1'b0;
        chk_eq("latency", 32'(lat), 32'(ref_lat(s)));
        chk_eq("data_out", data_out, exp);
        held = data_out;
        for (int i = 0; i < hold; i++) begin
            tick;
            chk_eq("hold_out_valid", 32'(out_valid), 32'd1);
            chk_eq("hold_data_out", data_out, held);
            chk_eq("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk_eq("post_out_valid", 32'(out_valid), 32'd0);
        chk_eq("post_in_ready", 32'(in_ready), 32'd1);
        chk_eq("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        op           = 2'd0;
        data_in      = '0;
        shift_amount = '0;
        repeat (3) tick;
        chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_data_out", data_out, 32'd0);
        chk_eq("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk_eq("rel_in_ready", 32'(in_ready), 32'd1);

        run_op(2'd1, 32'h8000_0000, 32'd31, 0);
        run_op(2'd2, 32'h8000_0000, 32'd4, 4);
        run_op(2'd0, 32'h0000_00FF, 32'd8, 1);
        run_op(2'd1, 32'hF000_000F, 32'd33, 0);
        run_op(2'd3, 32'h1234_5678, 32'd7, 2);
        run_op(2'd0, 32'hDEAD_BEEF, 32'd0, 0);
        run_op(2'd2, 32'h9000_0001, 32'd2, 0);
        run_op(2'd1, 32'hCAFE_F00D, 32'd16, 1);

        // Reset while the third stage is in flight.
        wait_ready;
        in_valid     = 1'b1;
        op           = 2'd1;
        data_in      = 32'h8000_0000;
        shift_amount = 32'd31;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        chk_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        chk_eq("midrst_busy", 32'(busy), 32'd0);
        chk_eq("midrst_data_out", data_out, 32'd0);
        chk_eq("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        run_op(2'd2, 32'h8765_4321, 32'd12, 1);

        for (int k = 0; k < 40; k++) begin
            logic [31:0] s;
            s = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 31));
            run_op(2'($urandom_range(0, 3)), $urandom, s, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
